// File: rtl/register_file.sv
// Multi-port register file with write/increment and a hardware clear sweep.
// Optional same-cycle read forwarding of accepted writes/increments: define REGFILE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [$clog2(NUM_REGS)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          inc,
    input  logic [$clog2(NUM_REGS)-1:0]   raddr_a,
    input  logic [$clog2(NUM_REGS)-1:0]   raddr_b,
    output logic [DATA_WIDTH-1:0]         rdata_a,
    output logic [DATA_WIDTH-1:0]         rdata_b,
    input  logic                          clr_start,
    output logic                          busy,
    output logic                          clr_done
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    sweep_clr;
    logic                    wr_acc, inc_acc;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    // Read mux padded to the full address space; holes read as zero
    logic [DATA_WIDTH-1:0]   rmux [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sweep_clr = 1'b0;
        busy      = 1'b0;
        clr_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                busy      = 1'b1;
                sweep_clr = 1'b1;
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == LAST_PTR) state_d = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_acc  = we & ~busy;
    assign inc_acc = inc & ~we & ~busy;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                regs[i] <= '0;
            else if (sweep_clr && ptr_q == ADDR_WIDTH'(i))
                regs[i] <= '0;
            else if (wr_acc && waddr == ADDR_WIDTH'(i))
                regs[i] <= wdata;
            else if (inc_acc && waddr == ADDR_WIDTH'(i))
                regs[i] <= regs[i] + DATA_WIDTH'(1);
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_rmux
        if (j < NUM_REGS) begin : g_live
            assign rmux[j] = regs[j];
        end else begin : g_hole
            assign rmux[j] = '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [DEPTH-1:0]      addr_ok;
    logic                  fwd_en;
    logic [DATA_WIDTH-1:0] fwd_data;

    for (genvar j = 0; j < DEPTH; j++) begin : g_ok
        assign addr_ok[j] = (j < NUM_REGS);
    end

    assign fwd_en   = (wr_acc | inc_acc) & addr_ok[waddr];
    assign fwd_data = wr_acc ? wdata : rmux[waddr] + DATA_WIDTH'(1);
    assign rdata_a  = (fwd_en && raddr_a == waddr) ? fwd_data : rmux[raddr_a];
    assign rdata_b  = (fwd_en && raddr_b == waddr) ? fwd_data : rmux[raddr_b];
`else
    assign rdata_a = rmux[raddr_a];
    assign rdata_b = rmux[raddr_b];
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a 4-entry instance plus a 3-entry instance for address holes.
module tb_register_file;
    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       we = 0, inc = 0, clr_start = 0;
    logic [1:0] waddr = 0, raddr_a = 0, raddr_b = 0;
    logic [7:0] wdata = 0;
    logic [7:0] rdata_a, rdata_b;
    logic       busy, clr_done;

    logic       we3 = 0, inc3 = 0, clr_start3 = 0;
    logic [1:0] waddr3 = 0, raddr_a3 = 0, raddr_b3 = 0;
    logic [7:0] wdata3 = 0;
    logic [7:0] rdata_a3, rdata_b3;
    logic       busy3, clr_done3;

    int vectors = 0;
    int errs    = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    register_file #(.DATA_WIDTH(8), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .inc(inc),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
    );

    register_file #(.DATA_WIDTH(8), .NUM_REGS(3)) dut3 (
        .clk(clk), .reset(reset), .we(we3), .waddr(waddr3), .wdata(wdata3), .inc(inc3),
        .raddr_a(raddr_a3), .raddr_b(raddr_b3), .rdata_a(rdata_a3), .rdata_b(rdata_b3),
        .clr_start(clr_start3), .busy(busy3), .clr_done(clr_done3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we = 1; waddr = a; wdata = d;
        @(negedge clk);
        we = 0;
    endtask

    task automatic rd2(input logic [1:0] a, input logic [1:0] b);
        raddr_a = a; raddr_b = b;
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        rd2(0, 1);
        check("rst_rdata_a", rdata_a, 8'h00);
        check("rst_rdata_b", rdata_b, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write and dual read
        wr(0, 8'h44);
        wr(1, 8'h22);
        rd2(0, 1);
        check("wr_r0", rdata_a, 8'h44);
        check("wr_r1", rdata_b, 8'h22);

        // Increment wrap and write-over-inc priority
        wr(2, 8'hFE);
        rd2(2, 2);
        inc = 1; waddr = 2;
        @(negedge clk);
        check("inc_ff", rdata_a, 8'hFF);
        @(negedge clk);
        check("inc_wrap", rdata_a, 8'h00);
        we = 1; wdata = 8'h10;
        @(negedge clk);
        we = 0; inc = 0;
        #1;
        check("we_over_inc", rdata_a, 8'h10);

        // Clear sweep with dropped ops and ignored clr_start while busy
        @(negedge clk);
        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);
        rd2(3, 0);
        check("pre_sweep_r3", rdata_a, 8'h44);
        clr_start = 1;
        @(negedge clk);
        clr_start = 0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("sweep_busy_c%0d", c), busy, 1'b1);
            check($sformatf("sweep_done_c%0d", c), clr_done, (c == 5) ? 1'b1 : 1'b0);
            we = (c == 2); wdata = 8'h99; waddr = 0;
            inc = (c == 4);
            clr_start = (c == 3);
            @(negedge clk);
        end
        we = 0; inc = 0; clr_start = 0;
        check("sweep_end_busy", busy, 1'b0);
        check("sweep_end_done", clr_done, 1'b0);
        rd2(0, 1);
        check("swept_r0", rdata_a, 8'h00);
        check("swept_r1", rdata_b, 8'h00);
        rd2(2, 3);
        check("swept_r2", rdata_a, 8'h00);
        check("swept_r3", rdata_b, 8'h00);
        @(negedge clk);
        check("no_restart_busy", busy, 1'b0);

        // Reset aborts a sweep; first edge after reset accepts a write
        wr(2, 8'h33);
        clr_start = 1;
        @(negedge clk);
        clr_start = 0;
        @(negedge clk);
        reset = 1;
        rd2(2, 1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", clr_done, 1'b0);
        check("abort_r2", rdata_a, 8'h00);
        @(negedge clk);
        reset = 0;
        we = 1; waddr = 3; wdata = 8'h55;
        @(negedge clk);
        we = 0;
        check("post_rst_done", clr_done, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        rd2(3, 3);
        check("post_rst_r3", rdata_a, 8'h55);

        // Same-cycle visibility depends on the forwarding build
        raddr_a = 1; raddr_b = 1;
        we = 1; waddr = 1; wdata = 8'h77;
        #1;
        check("fwd_wr_same", rdata_a, BYP ? 8'h77 : 8'h00);
        @(negedge clk);
        we = 0;
        #1;
        check("fwd_wr_next", rdata_a, 8'h77);
        inc = 1; waddr = 1;
        #1;
        check("fwd_inc_same", rdata_b, BYP ? 8'h78 : 8'h77);
        @(negedge clk);
        inc = 0;
        #1;
        check("fwd_inc_next", rdata_b, 8'h78);

        // Three-entry instance: address 3 is a hole
        @(negedge clk);
        we3 = 1;
        waddr3 = 0; wdata3 = 8'hA0; @(negedge clk);
        waddr3 = 1; wdata3 = 8'hA1; @(negedge clk);
        waddr3 = 2; wdata3 = 8'hA2; @(negedge clk);
        waddr3 = 3; wdata3 = 8'hEE; raddr_b3 = 3;
        #1;
        check("hole_rd_during_wr", rdata_b3, 8'h00);
        @(negedge clk);
        we3 = 0; inc3 = 1;
        @(negedge clk);
        inc3 = 0;
        raddr_a3 = 0; raddr_b3 = 3;
        #1;
        check("hole_rd3", rdata_b3, 8'h00);
        check("hole_r0", rdata_a3, 8'hA0);
        raddr_a3 = 1; raddr_b3 = 2;
        #1;
        check("hole_r1", rdata_a3, 8'hA1);
        check("hole_r2", rdata_b3, 8'hA2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the width of each register in bits.
REQ-002 The module SHALL have parameter NUM_REGS, default 4, giving the register count (2..16).
REQ-003 The module SHALL derive local parameter ADDR_WIDTH = $clog2(NUM_REGS) and SHALL NOT expose it as an override.
REQ-004 The module SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The module SHALL have port we  input  1  write enable.
REQ-007 The module SHALL have port waddr  input  ADDR_WIDTH  write/increment target.
REQ-008 The module SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-009 The module SHALL have port inc  input  1  increment the register at waddr.
REQ-010 The module SHALL have ports raddr_a and raddr_b  input  ADDR_WIDTH  read addresses.
REQ-011 The module SHALL have ports rdata_a and rdata_b  output  DATA_WIDTH  read data.
REQ-012 The module SHALL have port clr_start  input  1  request a clear sweep.
REQ-013 The module SHALL have port busy  output  1  high while a sweep is in progress.
REQ-014 The module SHALL have port clr_done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-015 Reads SHALL be combinational: rdata_x = reg[raddr_x]; an address >= NUM_REGS SHALL read 0.
REQ-016 When we=1 and busy=0, reg[waddr] SHALL take wdata at the edge; an address >= NUM_REGS SHALL be ignored.
REQ-017 When inc=1, we=0 and busy=0, reg[waddr] SHALL take reg[waddr]+1, wrapping from 2^DATA_WIDTH-1 to 0.
REQ-018 When we and inc are both high, we SHALL take priority and inc SHALL be ignored.
REQ-019 The clear FSM SHALL have the states IDLE, SWEEP and DONE.
REQ-020 The transition IDLE->SWEEP SHALL occur on clr_start=1, with the pointer set to 0.
REQ-021 In SWEEP, each cycle SHALL clear reg[ptr] and increment ptr.
REQ-022 SWEEP SHALL move to DONE after clearing reg[NUM_REGS-1].
REQ-023 DONE SHALL move to IDLE unconditionally.
REQ-024 busy SHALL be 1 in SWEEP and DONE.
REQ-025 clr_done SHALL be 1 only in DONE.
REQ-026 clr_done SHALL assert NUM_REGS+1 cycles after the edge that samples clr_start.
REQ-027 clr_start while busy=1 SHALL be ignored.
REQ-028 we and inc while busy=1 SHALL be dropped without effect.
REQ-029 clr_start and we together in IDLE: the write SHALL commit on that edge and is later cleared by the sweep.

Reset
REQ-030 reset=1 SHALL immediately force all registers to 0, the FSM to IDLE, ptr=0, busy=0 and clr_done=0.
REQ-031 A reset during SWEEP or DONE SHALL abort the sweep with no clr_done pulse.
REQ-032 The first edge after reset deasserts SHALL accept operations normally.

Configuration
REQ-033 With REGFILE_BYPASS_EN defined, a read port whose address equals waddr during an accepted write SHALL return wdata in the same cycle; accepted increments SHALL also be forwarded as reg[waddr]+1.
REQ-034 Without REGFILE_BYPASS_EN, read ports SHALL return the stored value only; new data SHALL be visible from the cycle after the edge.

Verification (DATA_WIDTH=8, NUM_REGS=4)
REQ-035 Write 0x44 to r0, then 0x22 to r1; raddr_a=0, raddr_b=1 -> rdata_a=0x44, rdata_b=0x22.
REQ-036 Write 0xFE to r2, then inc r2 on 2 edges -> 0xFF, then 0x00; we=1 with wdata=0x10 and inc=1 -> r2=0x10.
REQ-037 Load r0..r3=0x11..0x44, pulse clr_start -> busy high 5 cycles, clr_done on cycle 5, all regs 0; we with 0x99 mid-sweep -> no effect.
REQ-038 Assert reset 2 cycles into a sweep -> busy=0, regs 0, no clr_done; write 0x55 to r3 on the next edge -> r3=0x55.
REQ-039 Write 0x77 to r1 with raddr_a=1 -> rdata_a=0x77 in the same cycle if REGFILE_BYPASS_EN is defined, otherwise the old value then 0x77 next cycle.
REQ-040 raddr_b=3 with NUM_REGS=3 -> rdata_b=0; write to address 3 -> no register changes.
